mux_uart: RTL and testbench
===========================

MUX_UART -- requirements
Module: mux_uart

Interface
REQ-001 Parameter BASE_ADDR, default 16'hF200: status register address; data register at BASE_ADDR+1.
REQ-002 Parameter CLKS_PER_BIT, default 16: clocks per serial bit; even, at least 4.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addressBus  input  16  CPU bus address.
REQ-006 dataOutBus  input  8  CPU write data.
REQ-007 writeEnBus  input  1  CPU write strobe, one clock per write.
REQ-008 readEnBus  input  1  CPU read strobe, high during the clock the CPU latches read data.
REQ-009 selected  output  1  combinational: high when addressBus equals BASE_ADDR or BASE_ADDR+1.
REQ-010 dataInBus  output  8  combinational read data; 8'h00 when not selected.
REQ-011 txd  output  1  serial transmit line, idle high.
REQ-012 rxd  input  1  serial receive line, asynchronous, idle high.

Function
REQ-013 Status read value SHALL be {4'b0, framing_err, overrun, tx_ready, rx_ready} (bit0 = rx_ready).
REQ-014 Data read value SHALL be rx_data.
REQ-015 A readEnBus cycle at BASE_ADDR+1 SHALL clear rx_ready on the next edge.
REQ-016 A readEnBus cycle at BASE_ADDR SHALL clear overrun and framing_err on the next edge.
REQ-017 A writeEnBus cycle at BASE_ADDR+1 with tx_ready=1 SHALL latch dataOutBus and clear tx_ready on the next edge.
REQ-018 A data write while tx_ready=0 SHALL be ignored; writes to BASE_ADDR SHALL be ignored.
REQ-019 TX FSM states: IDLE, START, DATA, STOP; each bit held exactly CLKS_PER_BIT clocks.
REQ-020 txd SHALL go low on the edge that accepts the write (start bit), then send 8 data bits LSB first, then one stop bit (high).
REQ-021 tx_ready SHALL return to 1 on the edge ending the stop bit; the total frame is 10*CLKS_PER_BIT clocks.
REQ-022 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-023 RX FSM states: IDLE, START, DATA, STOP.
REQ-024 RX IDLE->START on a synchronized high-to-low transition.
REQ-025 In START, rxd SHALL be resampled after CLKS_PER_BIT/2 clocks; if high, return to IDLE (false start, no flag).
REQ-026 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first.
REQ-027 STOP SHALL sample once at the stop-bit midpoint, then return to IDLE.
REQ-028 If stop=1, load rx_data and set rx_ready; if rx_ready was already 1, overwrite rx_data and set overrun.
REQ-029 If stop=0, discard the byte, set framing_err, and leave rx_data and rx_ready unchanged.
REQ-030 If a byte completes on the same edge that a data read clears rx_ready, set wins: rx_ready stays 1 and overrun is not set.
REQ-031 If a flag is set on the same edge that a status read clears flags, set wins.
REQ-032 TX and RX SHALL operate concurrently and independently.

Reset
REQ-033 Reset SHALL force: txd=1, tx_ready=1, rx_ready=0, overrun=0, framing_err=0, rx_data=8'h00, both FSMs IDLE, all counters 0, synchronizer flops 1.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately (txd high asynchronously); no partial byte SHALL be delivered.

Structure
REQ-035 Shared package SHALL hold: status bit positions, FSM state enums, and the BASE_ADDR default.
REQ-036 Transmitter SHALL be sub-module uart_tx (clock, reset, start, data, txd, busy); receive logic and register decode stay in mux_uart.

Verification (CLKS_PER_BIT=4)
REQ-037 After reset, read BASE_ADDR -> 8'h02; txd=1.
REQ-038 Write 8'hA5 to F201 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; tx_ready=0 for 40 clocks, then 1.
REQ-039 Write 8'h11 during that frame -> ignored; the frame is unchanged.
REQ-040 Drive RX frame 8'h3C -> rx_ready=1; F201 reads 8'h3C; rx_ready=0 after the read strobe.
REQ-041 Two RX frames 8'h01, 8'h02 with no read -> status 8'h05 (overrun), data reads 8'h02; status read clears overrun.
REQ-042 RX frame with stop bit 0 -> framing_err set, rx_ready=0; a 1-clock low glitch on rxd -> no flags and no byte.

Source files
------------

// File: rtl/mux_uart_pkg.sv
// Shared definitions for the memory-mapped UART.
//   - default base address of the two-register window
//   - bit positions inside the status register
//   - state encodings of the transmit and receive state machines
//   - pack_status(): assembles the status byte from the individual flags
package mux_uart_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hF200;

  // Status register layout: {4'b0, framing_err, overrun, tx_ready, rx_ready}
  localparam int STAT_RX_READY    = 0;
  localparam int STAT_TX_READY    = 1;
  localparam int STAT_OVERRUN     = 2;
  localparam int STAT_FRAMING_ERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [7:0] pack_status(input logic framing_err,
                                             input logic overrun,
                                             input logic tx_ready,
                                             input logic rx_ready);
    logic [7:0] s;
    s                   = 8'h00;
    s[STAT_RX_READY]    = rx_ready;
    s[STAT_TX_READY]    = tx_ready;
    s[STAT_OVERRUN]     = overrun;
    s[STAT_FRAMING_ERR] = framing_err;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Serial transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Ports:
//   clock  in   system clock (rising edge)
//   reset  in   asynchronous active-high reset; forces txd high at once
//   start  in   accept 'data' and begin a frame (only honoured when idle)
//   data   in   byte to send
//   txd    out  serial line, idle high
//   busy   out  high from the accepting edge until the stop bit has ended
module uart_tx
  import mux_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

  // txd is registered so the start bit appears on the accepting edge itself.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    case (state_reg)
      TX_IDLE: begin
        txd_next = 1'b1;
        cnt_next = '0;
        if (start) begin
          shift_next = data;
          txd_next   = 1'b0;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          txd_next   = shift_reg[0];
          state_next = TX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            txd_next   = 1'b1;
            state_next = TX_STOP;
          end else begin
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
            bit_next   = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = TX_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign txd  = txd_reg;
  assign busy = (state_reg != TX_IDLE);

endmodule

// File: rtl/mux_uart.sv
// Memory-mapped UART on an 8-bit CPU bus.
//   BASE_ADDR   : status register {4'b0, framing_err, overrun, tx_ready, rx_ready}
//   BASE_ADDR+1 : read = received byte, write = byte to transmit
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   addressBus, dataOutBus  CPU address and write data
//   writeEnBus, readEnBus   one-clock CPU write / read strobes
//   selected, dataInBus     combinational decode and read data
//   txd, rxd                serial lines (idle high)
module mux_uart
  import mux_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  input  logic        readEnBus,
  output logic        selected,
  output logic [7:0]  dataInBus,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0]   DATA_ADDR = BASE_ADDR + 16'd1;
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- bus decode ----------------
  logic status_sel, data_sel, status_rd, data_rd, tx_start, tx_busy, tx_ready;

  assign status_sel = (addressBus == BASE_ADDR);
  assign data_sel   = (addressBus == DATA_ADDR);
  assign selected   = status_sel | data_sel;
  assign status_rd  = readEnBus & status_sel;
  assign data_rd    = readEnBus & data_sel;
  assign tx_ready   = ~tx_busy;
  assign tx_start   = writeEnBus & data_sel & tx_ready;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock (clock),
    .reset (reset),
    .start (tx_start),
    .data  (dataOutBus),
    .txd   (txd),
    .busy  (tx_busy)
  );

  // ---------------- receiver ----------------
  logic [1:0]    sync_reg;
  logic          rx_prev_reg;
  logic          rxd_s;
  rx_state_t     rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          done_ok, done_err;

  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_ready_reg, rx_ready_next;
  logic       overrun_reg, overrun_next;
  logic       framing_reg, framing_next;

  assign rxd_s = sync_reg[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg     <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= 8'h00;
      rx_ready_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      framing_reg  <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], rxd};
      rx_prev_reg  <= rxd_s;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_ready_reg <= rx_ready_next;
      overrun_reg  <= overrun_next;
      framing_reg  <= framing_next;
    end
  end

  // After the half-bit check in START, every later sample lands one full
  // bit period after the previous one, i.e. near each bit's midpoint.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    done_ok       = 1'b0;
    done_err      = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev_reg && !rxd_s) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt_reg == HALF) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxd_s, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
          else                    rx_bit_next   = rx_bit_reg + 1'b1;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          done_ok       = rxd_s;
          done_err      = ~rxd_s;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // Flag updates: a set on the same edge as a clearing read always wins.
  // Overrun needs the byte to land on an unread buffer, so a data read on
  // the completing edge counts as having consumed the old byte.
  always_comb begin
    rx_data_next  = done_ok ? rx_shift_reg : rx_data_reg;
    rx_ready_next = done_ok ? 1'b1 : (data_rd ? 1'b0 : rx_ready_reg);
    overrun_next  = (done_ok && rx_ready_reg && !data_rd) ? 1'b1 :
                    (status_rd ? 1'b0 : overrun_reg);
    framing_next  = done_err ? 1'b1 : (status_rd ? 1'b0 : framing_reg);
  end

  always_comb begin
    dataInBus = 8'h00;
    if (status_sel)
      dataInBus = pack_status(framing_reg, overrun_reg, tx_ready, rx_ready_reg);
    else if (data_sel)
      dataInBus = rx_data_reg;
  end

endmodule

// File: tb/tb_mux_uart.sv
module tb_mux_uart;

  localparam logic [15:0] STAT = 16'hF200;
  localparam logic [15:0] DATA = 16'hF201;

  logic        clock;
  logic        reset;
  logic [15:0] addressBus;
  logic [7:0]  dataOutBus;
  logic        writeEnBus;
  logic        readEnBus;
  logic        selected;
  logic [7:0]  dataInBus;
  logic        txd;
  logic        rxd;

  int checks = 0;
  int errors = 0;

  mux_uart #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .addressBus (addressBus),
    .dataOutBus (dataOutBus),
    .writeEnBus (writeEnBus),
    .readEnBus  (readEnBus),
    .selected   (selected),
    .dataInBus  (dataInBus),
    .txd        (txd),
    .rxd        (rxd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        rd;
    logic        exp_sel;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    addressBus = a;
    #1 d = dataInBus;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    addressBus = a;
    readEnBus  = 1'b1;
    #1 d = dataInBus;
    @(posedge clock);
    #1;
    readEnBus  = 1'b0;
    addressBus = STAT;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addressBus = a;
    dataOutBus = d;
    writeEnBus = 1'b1;
    @(posedge clock);
    #1;
    writeEnBus = 1'b0;
    addressBus = STAT;
  endtask

  // Drives one serial frame (4 clocks per bit) plus 4 idle clocks.
  // rd_at >= 0 pulses a data read during that clock of the frame.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int rd_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 44; i++) begin
      @(negedge clock);
      rxd = (i < 40) ? frame[i/4] : 1'b1;
      if (i == rd_at) begin
        addressBus = DATA;
        readEnBus  = 1'b1;
      end else begin
        readEnBus  = 1'b0;
        addressBus = STAT;
      end
    end
    @(negedge clock);
    readEnBus = 1'b0;
    $display("rx frame %02h stop=%0b sent", b, stop_bit);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] tx_frame;

    vecs[0] = '{STAT,     1'b0, 8'h00, 1'b1, 1'b1, 8'h02};
    vecs[1] = '{DATA,     1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{16'hF1FF, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{16'hF202, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{STAT,     1'b1, 8'h55, 1'b0, 1'b1, 8'h02};
    vecs[6] = '{STAT,     1'b0, 8'h00, 1'b1, 1'b1, 8'h02};
    vecs[7] = '{DATA,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00};

    reset = 1'b1; rxd = 1'b1; addressBus = STAT; dataOutBus = 8'h00;
    writeEnBus = 1'b0; readEnBus = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // ---- reset state ----
    #1 check("reset_txd", {7'b0, txd}, 8'h01);
    peek(STAT, d); check("reset_status", d, 8'h02);
    peek(DATA, d); check("reset_data", d, 8'h00);
    $display("reset state checked");

    // ---- register decode table ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      addressBus = vecs[i].addr;
      writeEnBus = vecs[i].wr;
      dataOutBus = vecs[i].wdata;
      readEnBus  = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_selected", i), {7'b0, selected}, {7'b0, vecs[i].exp_sel});
      check($sformatf("vec%0d_data", i), dataInBus, vecs[i].exp_data);
      @(posedge clock);
      #1;
      writeEnBus = 1'b0; readEnBus = 1'b0; addressBus = STAT;
      $display("vector %0d addr %04h wr %0b rd %0b done", i, vecs[i].addr, vecs[i].wr, vecs[i].rd);
    end

    // ---- transmit A5, with an ignored write of 11 mid-frame ----
    tx_frame = {1'b1, 8'hA5, 1'b0};
    bus_write(DATA, 8'hA5);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clock);
      if (k == 11) begin
        writeEnBus = 1'b0;
        addressBus = STAT;
      end
      #1;
      if (k < 40) begin
        check($sformatf("tx_bit_clk%0d", k), {7'b0, txd}, {7'b0, tx_frame[k/4]});
        check($sformatf("tx_ready_busy_clk%0d", k), {7'b0, dataInBus[1]}, 8'h00);
      end else begin
        check("tx_txd_after_frame", {7'b0, txd}, 8'h01);
        check("tx_ready_after_frame", {7'b0, dataInBus[1]}, 8'h01);
      end
      if (k == 10) begin
        addressBus = DATA;
        dataOutBus = 8'h11;
        writeEnBus = 1'b1;
      end
    end
    $display("tx frame A5 checked");

    // ---- receive 3C ----
    send_rx(8'h3C, 1'b1, -1);
    peek(STAT, d); check("rx3c_status", d, 8'h03);
    bus_read(DATA, d); check("rx3c_data", d, 8'h3C);
    peek(STAT, d); check("rx3c_status_after_read", d, 8'h02);

    // ---- byte completes on the edge of a data read: set wins ----
    send_rx(8'h55, 1'b1, -1);
    peek(STAT, d); check("rx55_status", d, 8'h03);
    send_rx(8'h66, 1'b1, 40);
    peek(STAT, d); check("same_edge_status", d, 8'h03);
    peek(DATA, d); check("same_edge_data", d, 8'h66);
    bus_read(DATA, d); check("same_edge_read", d, 8'h66);
    peek(STAT, d); check("same_edge_cleared", d, 8'h02);

    // ---- overrun, with the transmitter busy concurrently ----
    send_rx(8'h01, 1'b1, -1);
    send_rx(8'h02, 1'b1, -1);
    bus_write(DATA, 8'h77);
    bus_read(STAT, d); check("overrun_status", d, 8'h05);
    bus_read(DATA, d); check("overrun_data", d, 8'h02);
    peek(STAT, d); check("overrun_cleared", d, 8'h00);
    repeat (45) @(posedge clock);
    peek(STAT, d); check("tx77_done_status", d, 8'h02);

    // ---- framing error ----
    send_rx(8'hAA, 1'b0, -1);
    peek(STAT, d); check("framing_status", d, 8'h0A);
    peek(DATA, d); check("framing_data_kept", d, 8'h02);
    bus_read(STAT, d); check("framing_read", d, 8'h0A);
    peek(STAT, d); check("framing_cleared", d, 8'h02);

    // ---- one-clock glitch on rxd ----
    @(negedge clock); rxd = 1'b0;
    @(negedge clock); rxd = 1'b1;
    repeat (20) @(posedge clock);
    peek(STAT, d); check("glitch_status", d, 8'h02);
    peek(DATA, d); check("glitch_data", d, 8'h02);
    $display("glitch checked");

    // ---- reset in the middle of TX and RX frames ----
    bus_write(DATA, 8'h00);
    @(negedge clock); rxd = 1'b0;
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    #1 check("midframe_reset_txd", {7'b0, txd}, 8'h01);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(posedge clock);
    peek(STAT, d); check("after_reset_status", d, 8'h02);
    peek(DATA, d); check("after_reset_data", d, 8'h00);
    #1 check("after_reset_txd", {7'b0, txd}, 8'h01);
    $display("mid-frame reset checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
